inference_sequencer: RTL and testbench

//  Batch scheduler for the 784-128-32-10 MNIST datapath. It runs IMG_COUNT images back to back through the

---
 rtl/mnist_pkg.sv | 33 +++
 rtl/inference_sequencer_if.sv | 47 ++++
 rtl/inference_sequencer_run_delay_line.sv | 41 ++++
 rtl/inference_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_inference_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mnist_pkg.sv
// Shared constants and types for the MNIST 784-128-32-10 inference control path.
package mnist_pkg;

    localparam int N_IN1_DEF = 784;
    localparam int N_IN2_DEF = 128;
    localparam int N_IN3_DEF = 32;
    localparam int N_OUT     = 10;

    localparam int ADDR_W  = 32;
    localparam int BASE_W  = 20;
    localparam int MAX_IMG = 16;

    // Bits needed to hold an image count in the range 0..max_img inclusive.
    function automatic int img_w_f(input int max_img);
        return $clog2(max_img + 1);
    endfunction

    localparam int IMG_W   = img_w_f(MAX_IMG);
    localparam int CLASS_W = $clog2(N_OUT);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_F1   = 4'd1,
        S_W1   = 4'd2,
        S_F2   = 4'd3,
        S_W2   = 4'd4,
        S_F3   = 4'd5,
        S_W3   = 4'd6,
        S_WR   = 4'd7,
        S_FIN  = 4'd8
    } seq_state_t;

endpackage

// File: rtl/inference_sequencer_if.sv
// Host handshake plus layer-datapath strobes/bus seen by the batch sequencer.
interface inference_sequencer_if;
    import mnist_pkg::*;

    // host side
    logic               start;
    logic               abort;
    logic [IMG_W-1:0]   img_count;
    logic               busy;
    logic               done;
    logic               err_timeout;

    // layer datapath side
    logic               l1_done;
    logic               l2_done;
    logic               l3_done;
    logic               pred_valid;
    logic [CLASS_W-1:0] pred_class;
    logic [ADDR_W-1:0]  current_addr;
    logic [BASE_W-1:0]  img_base;
    logic               l1_run;
    logic               l2_run;
    logic               l3_run;

    // result buffer write port
    logic               res_we;
    logic [IMG_W-1:0]   res_addr;
    logic [CLASS_W-1:0] res_data;

    // sequencer view
    modport master (
        input  start, abort, img_count,
        input  l1_done, l2_done, l3_done, pred_valid, pred_class,
        output busy, done, err_timeout,
        output current_addr, img_base, l1_run, l2_run, l3_run,
        output res_we, res_addr, res_data
    );

    // host / datapath view
    modport slave (
        output start, abort, img_count,
        output l1_done, l2_done, l3_done, pred_valid, pred_class,
        input  busy, done, err_timeout,
        input  current_addr, img_base, l1_run, l2_run, l3_run,
        input  res_we, res_addr, res_data
    );
endinterface

// File: rtl/inference_sequencer_run_delay_line.sv
// Shift register that delays the layer-1 address-valid flag by the image ROM latency.
// A flush clears every stage so an aborted feed stops driving run on the next cycle.
module run_delay_line #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic din,
    output logic dout
);
    genvar gi;

    generate
        if (DEPTH == 0) begin : g_bypass
            assign dout = din;
        end else begin : g_shift
            logic [DEPTH-1:0] stage_q;
            logic [DEPTH-1:0] stage_d;

            for (gi = 0; gi < DEPTH; gi++) begin : g_stage
                if (gi == 0) begin : g_head
                    assign stage_d[gi] = flush ? 1'b0 : din;
                end else begin : g_tail
                    assign stage_d[gi] = flush ? 1'b0 : stage_q[gi-1];
                end
            end

            // Advance the delay chain one stage per cycle.
            always_ff @(posedge clk) begin
                if (rst) begin
                    stage_q <= '0;
                end else begin
                    stage_q <= stage_d;
                end
            end

            assign dout = stage_q[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/inference_sequencer.sv
// Batch scheduler: runs img_count images through the three layer stages, drives
// their run strobes and shared address, and writes each argmax into the result buffer.
module inference_sequencer
    import mnist_pkg::*;
#(
    parameter int N_IN1    = N_IN1_DEF,
    parameter int N_IN2    = N_IN2_DEF,
    parameter int N_IN3    = N_IN3_DEF,
    parameter int ROM_LAT  = 1,
    parameter int WAIT_MAX = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    inference_sequencer_if.master bus
);
    localparam int                 WAIT_W    = $clog2(WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(WAIT_MAX - 1);
    localparam logic [ADDR_W-1:0]  LAST1     = ADDR_W'(N_IN1 - 1);
    localparam logic [ADDR_W-1:0]  LAST2     = ADDR_W'(N_IN2 - 1);
    localparam logic [ADDR_W-1:0]  LAST3     = ADDR_W'(N_IN3 - 1);
    localparam logic [IMG_W-1:0]   IMG_CAP   = IMG_W'(MAX_IMG);
    localparam logic [BASE_W-1:0]  BASE_STEP = BASE_W'(N_IN1);

    seq_state_t         state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [IMG_W-1:0]   idx_q, idx_d;
    logic [BASE_W-1:0]  base_q, base_d;
    logic [IMG_W-1:0]   count_q, count_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               res_we_q, res_we_d;
    logic [IMG_W-1:0]   res_addr_q, res_addr_d;
    logic [CLASS_W-1:0] res_data_q, res_data_d;

    logic               wait_active;
    logic [IMG_W-1:0]   count_clamp;
    logic [IMG_W-1:0]   idx_inc;
    logic               f1_valid;
    logic               l1_run_dly;

    assign count_clamp = (bus.img_count > IMG_CAP) ? IMG_CAP : bus.img_count;
    assign idx_inc     = idx_q + 1'b1;
    assign f1_valid    = (state_q == S_F1);

    // Next-state, counters and registered outputs; abort overrides everything last.
    always_comb begin
        state_d     = state_q;
        addr_d      = '0;
        wait_d      = '0;
        idx_d       = idx_q;
        base_d      = base_q;
        count_d     = count_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        res_we_d    = 1'b0;
        res_addr_d  = res_addr_q;
        res_data_d  = res_data_q;
        wait_active = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    count_d = count_clamp;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = (count_clamp == '0) ? S_FIN : S_F1;
                end
            end
            S_F1: begin
                if (addr_q == LAST1) state_d = S_W1;
                else                 addr_d  = addr_q + 1'b1;
            end
            S_W1: begin
                if (bus.l1_done) state_d = S_F2;
                else             wait_active = 1'b1;
            end
            S_F2: begin
                if (addr_q == LAST2) state_d = S_W2;
                else                 addr_d  = addr_q + 1'b1;
            end
            S_W2: begin
                if (bus.l2_done) state_d = S_F3;
                else             wait_active = 1'b1;
            end
            S_F3: begin
                if (addr_q == LAST3) state_d = S_W3;
                else                 addr_d  = addr_q + 1'b1;
            end
            S_W3: begin
                if (bus.l3_done) state_d = S_WR;
                else             wait_active = 1'b1;
            end
            S_WR: begin
                if (bus.pred_valid) begin
                    res_we_d   = 1'b1;
                    res_addr_d = idx_q;
                    res_data_d = bus.pred_class;
                    idx_d      = idx_inc;
                    base_d     = base_q + BASE_STEP;
                    state_d    = (idx_inc < count_q) ? S_F1 : S_FIN;
                end else begin
                    wait_active = 1'b1;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                idx_d   = '0;
                base_d  = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A stalled layer or argmax ends the batch without a done pulse.
        if (wait_active) begin
            if (wait_q == WAIT_LAST) begin
                err_d   = 1'b1;
                busy_d  = 1'b0;
                idx_d   = '0;
                base_d  = '0;
                state_d = S_IDLE;
            end else begin
                wait_d = wait_q + 1'b1;
            end
        end

        // Abort beats start, done and timeout; partial results already written stay.
        if (bus.abort) begin
            state_d  = S_IDLE;
            addr_d   = '0;
            wait_d   = '0;
            idx_d    = '0;
            base_d   = '0;
            count_d  = count_q;
            err_d    = err_q;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            res_we_d = 1'b0;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wait_q     <= '0;
            idx_q      <= '0;
            base_q     <= '0;
            count_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            res_we_q   <= 1'b0;
            res_addr_q <= '0;
            res_data_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wait_q     <= wait_d;
            idx_q      <= idx_d;
            base_q     <= base_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            res_we_q   <= res_we_d;
            res_addr_q <= res_addr_d;
            res_data_q <= res_data_d;
        end
    end

    // Layer-1 data arrives from the image ROM ROM_LAT cycles after its address.
    run_delay_line #(
        .DEPTH (ROM_LAT)
    ) u_l1_delay (
        .clk   (clk),
        .rst   (rst),
        .flush (bus.abort),
        .din   (f1_valid),
        .dout  (l1_run_dly)
    );

    assign bus.current_addr = addr_q;
    assign bus.img_base     = base_q;
    assign bus.l1_run       = l1_run_dly;
    assign bus.l2_run       = (state_q == S_F2);
    assign bus.l3_run       = (state_q == S_F3);
    assign bus.res_we       = res_we_q;
    assign bus.res_addr     = res_addr_q;
    assign bus.res_data     = res_data_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.err_timeout  = err_q;
endmodule

// File: tb/tb_inference_sequencer.sv
// Directed bench for inference_sequencer: stub layers answer each run burst with a
// done pulse, a stub argmax returns classes from a table, and a monitor logs activity.
module tb_inference_sequencer;
    import mnist_pkg::*;

    localparam int N1   = 784;
    localparam int N2   = 128;
    localparam int N3   = 32;
    localparam int WMAX = 1023;

    logic clk;
    logic rst;

    inference_sequencer_if bus_if ();

    inference_sequencer #(
        .N_IN1    (N1),
        .N_IN2    (N2),
        .N_IN3    (N3),
        .ROM_LAT  (1),
        .WAIT_MAX (WMAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks;
    int n_errors;

    // monitor state (written only by the monitor/stub process)
    int cyc, n_l1, n_l2, n_l3, n_done, done_cyc, l2_fall_cyc, err_rise_cyc, n_pred;
    int cd1, cd2, cd3, cdp;
    int rise_base[$];
    int rise_addr[$];
    int rise_cyc[$];
    int we_addr[$];
    int we_data[$];
    int we_cyc[$];
    int res_mem[32];
    logic l1_prev, l2_prev, l3_prev, err_prev;

    // controls written only by the main sequence
    int class_tab[64];
    bit en_l2 = 1'b1;
    int spur_l3_cyc = -1;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic pulse_start(input int n);
        bus_if.img_count = IMG_W'(n);
        bus_if.start     = 1'b1;
        tick();
        bus_if.start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int base_done, input int budget);
        int k = 0;
        while (n_done == base_done && k < budget) begin
            tick();
            k++;
        end
        check_value(tag, (n_done > base_done) ? 1 : 0, 1);
    endtask

    // Stub layers/argmax and activity monitor, evaluated on the falling edge.
    initial begin
        cyc = 0; n_l1 = 0; n_l2 = 0; n_l3 = 0; n_done = 0; n_pred = 0;
        done_cyc = -1; l2_fall_cyc = -1; err_rise_cyc = -1;
        cd1 = 0; cd2 = 0; cd3 = 0; cdp = 0;
        l1_prev = 1'b0; l2_prev = 1'b0; l3_prev = 1'b0; err_prev = 1'b0;
        bus_if.l1_done = 1'b0; bus_if.l2_done = 1'b0; bus_if.l3_done = 1'b0;
        bus_if.pred_valid = 1'b0; bus_if.pred_class = '0;
        forever begin
            @(negedge clk);
            cyc++;
            bus_if.l1_done    = 1'b0;
            bus_if.l2_done    = 1'b0;
            bus_if.l3_done    = 1'b0;
            bus_if.pred_valid = 1'b0;

            if (bus_if.l1_run) n_l1++;
            if (bus_if.l2_run) n_l2++;
            if (bus_if.l3_run) n_l3++;
            if (bus_if.l1_run && !l1_prev) begin
                rise_base.push_back(int'(bus_if.img_base));
                rise_addr.push_back(int'(bus_if.current_addr));
                rise_cyc.push_back(cyc);
            end
            if (!bus_if.l2_run && l2_prev) l2_fall_cyc = cyc;
            if (bus_if.err_timeout && !err_prev) begin
                err_rise_cyc = cyc;
                $display("[%0d] timeout flagged", cyc);
            end
            if (bus_if.res_we) begin
                we_addr.push_back(int'(bus_if.res_addr));
                we_data.push_back(int'(bus_if.res_data));
                we_cyc.push_back(cyc);
                res_mem[bus_if.res_addr] = int'(bus_if.res_data);
                $display("[%0d] result write addr=%0d class=%0d", cyc, bus_if.res_addr, bus_if.res_data);
            end
            if (bus_if.done) begin
                n_done++;
                done_cyc = cyc;
                $display("[%0d] batch done", cyc);
            end

            if (cdp > 0) begin
                cdp--;
                if (cdp == 0) begin
                    bus_if.pred_valid = 1'b1;
                    bus_if.pred_class = CLASS_W'(class_tab[n_pred]);
                    n_pred++;
                end
            end
            if (cd1 > 0) begin cd1--; if (cd1 == 0) bus_if.l1_done = 1'b1; end
            if (cd2 > 0) begin cd2--; if (cd2 == 0) bus_if.l2_done = en_l2; end
            if (cd3 > 0) begin
                cd3--;
                if (cd3 == 0) begin
                    bus_if.l3_done = 1'b1;
                    cdp = 3;
                end
            end
            if (cyc == spur_l3_cyc) bus_if.l3_done = 1'b1;

            if (!bus_if.l1_run && l1_prev) cd1 = 5;
            if (!bus_if.l2_run && l2_prev) cd2 = 5;
            if (!bus_if.l3_run && l3_prev) cd3 = 5;
            l1_prev  = bus_if.l1_run;
            l2_prev  = bus_if.l2_run;
            l3_prev  = bus_if.l3_run;
            err_prev = bus_if.err_timeout;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    // Directed test sequence.
    initial begin
        int s_l1, s_l2, s_l3, s_we, s_rise, s_done, c0, k;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus_if.start = 1'b0;
        bus_if.abort = 1'b0;
        bus_if.img_count = '0;
        repeat (4) tick();

        check_value("rst_busy",  bus_if.busy, 0);
        check_value("rst_done",  bus_if.done, 0);
        check_value("rst_err",   bus_if.err_timeout, 0);
        check_value("rst_addr",  bus_if.current_addr, 0);
        check_value("rst_base",  bus_if.img_base, 0);
        check_value("rst_runs",  {bus_if.l1_run, bus_if.l2_run, bus_if.l3_run, bus_if.res_we}, 0);
        rst = 1'b0;
        repeat (2) tick();

        // 1: single image, class 7
        s_l1 = n_l1; s_l2 = n_l2; s_l3 = n_l3; s_we = we_data.size(); s_rise = rise_cyc.size(); s_done = n_done;
        class_tab[n_pred] = 7;
        c0 = cyc;
        pulse_start(1);
        check_value("t1_busy", bus_if.busy, 1);
        wait_done("t1_done_seen", s_done, 1500);
        check_value("t1_done_busy_low", bus_if.busy, 0);
        check_value("t1_l1_cycles", n_l1 - s_l1, N1);
        check_value("t1_l2_cycles", n_l2 - s_l2, N2);
        check_value("t1_l3_cycles", n_l3 - s_l3, N3);
        check_value("t1_l1_rises", rise_cyc.size() - s_rise, 1);
        check_value("t1_l1_start", rise_cyc[s_rise] - c0, 2);
        check_value("t1_l1_addr_lag", rise_addr[s_rise], 1);
        check_value("t1_writes", we_data.size() - s_we, 1);
        check_value("t1_res_addr", we_addr[s_we], 0);
        check_value("t1_res_data", we_data[s_we], 7);
        check_value("t1_done_after_we", done_cyc - we_cyc[s_we], 1);
        repeat (3) tick();

        // 2: three images, classes 2,9,0
        s_l1 = n_l1; s_we = we_data.size(); s_rise = rise_cyc.size(); s_done = n_done;
        class_tab[n_pred] = 2; class_tab[n_pred + 1] = 9; class_tab[n_pred + 2] = 0;
        pulse_start(3);
        wait_done("t2_done_seen", s_done, 4000);
        repeat (5) tick();
        check_value("t2_done_count", n_done - s_done, 1);
        check_value("t2_l1_cycles", n_l1 - s_l1, 3 * N1);
        check_value("t2_writes", we_data.size() - s_we, 3);
        for (int i = 0; i < 3; i++) begin
            check_value($sformatf("t2_res_addr%0d", i), we_addr[s_we + i], i);
            check_value($sformatf("t2_base%0d", i), rise_base[s_rise + i], i * N1);
        end
        check_value("t2_res_data0", we_data[s_we], 2);
        check_value("t2_res_data1", we_data[s_we + 1], 9);
        check_value("t2_res_data2", we_data[s_we + 2], 0);

        // 3: empty batch
        s_l1 = n_l1; s_l2 = n_l2; s_l3 = n_l3; s_we = we_data.size(); s_done = n_done;
        c0 = cyc;
        pulse_start(0);
        wait_done("t3_done_seen", s_done, 20);
        check_value("t3_done_latency", done_cyc - c0, 2);
        check_value("t3_no_runs", (n_l1 - s_l1) + (n_l2 - s_l2) + (n_l3 - s_l3), 0);
        check_value("t3_no_write", we_data.size() - s_we, 0);
        repeat (3) tick();

        // 4: l2_done withheld -> timeout, then restart clears the flag
        en_l2 = 1'b0;
        s_we = we_data.size(); s_done = n_done;
        pulse_start(1);
        k = 0;
        while (!bus_if.err_timeout && k < 3000) begin tick(); k++; end
        check_value("t4_err_set", bus_if.err_timeout, 1);
        check_value("t4_busy_low", bus_if.busy, 0);
        check_value("t4_wait_len", err_rise_cyc - l2_fall_cyc, WMAX);
        repeat (10) tick();
        check_value("t4_no_done", n_done - s_done, 0);
        check_value("t4_no_write", we_data.size() - s_we, 0);
        check_value("t4_err_sticky", bus_if.err_timeout, 1);
        en_l2 = 1'b1;
        class_tab[n_pred] = 5;
        s_done = n_done;
        pulse_start(1);
        check_value("t4_err_cleared", bus_if.err_timeout, 0);
        check_value("t4_restart_busy", bus_if.busy, 1);
        wait_done("t4_restart_done", s_done, 1500);
        check_value("t4_restart_res", res_mem[0], 5);
        repeat (3) tick();

        // 5: abort at address 400 of image 1
        s_we = we_data.size(); s_done = n_done;
        class_tab[n_pred] = 4; class_tab[n_pred + 1] = 6; class_tab[n_pred + 2] = 1;
        pulse_start(3);
        k = 0;
        while (!(bus_if.img_base == BASE_W'(N1) && bus_if.current_addr == 400) && k < 3000) begin
            tick();
            k++;
        end
        check_value("t5_reached_addr400", (k < 3000) ? 1 : 0, 1);
        bus_if.abort = 1'b1;
        tick();
        bus_if.abort = 1'b0;
        check_value("t5_l1_run_low", bus_if.l1_run, 0);
        check_value("t5_l2l3_low", {bus_if.l2_run, bus_if.l3_run}, 0);
        check_value("t5_addr_zero", bus_if.current_addr, 0);
        check_value("t5_base_zero", bus_if.img_base, 0);
        check_value("t5_busy_low", bus_if.busy, 0);
        repeat (20) tick();
        check_value("t5_no_done", n_done - s_done, 0);
        check_value("t5_one_write", we_data.size() - s_we, 1);
        check_value("t5_img0_kept", res_mem[0], 4);
        s_we = we_data.size(); s_done = n_done;
        class_tab[n_pred] = 3; class_tab[n_pred + 1] = 8;
        pulse_start(2);
        wait_done("t5_restart_done", s_done, 3000);
        check_value("t5_restart_writes", we_data.size() - s_we, 2);
        check_value("t5_restart_res0", res_mem[0], 3);
        check_value("t5_restart_res1", res_mem[1], 8);
        repeat (3) tick();

        // start and abort together: abort wins
        s_l1 = n_l1;
        bus_if.abort = 1'b1;
        pulse_start(2);
        bus_if.abort = 1'b0;
        check_value("tsa_busy_low", bus_if.busy, 0);
        repeat (5) tick();
        check_value("tsa_no_feed", n_l1 - s_l1, 0);

        // 6: start re-pulsed while busy and spurious l3_done during F1
        s_l1 = n_l1; s_l3 = n_l3; s_we = we_data.size(); s_done = n_done;
        class_tab[n_pred] = 1; class_tab[n_pred + 1] = 2;
        spur_l3_cyc = cyc + 100;
        pulse_start(2);
        repeat (50) tick();
        pulse_start(5);
        wait_done("t6_done_seen", s_done, 3000);
        repeat (5) tick();
        check_value("t6_done_count", n_done - s_done, 1);
        check_value("t6_writes", we_data.size() - s_we, 2);
        check_value("t6_res_data0", we_data[s_we], 1);
        check_value("t6_res_addr1", we_addr[s_we + 1], 1);
        check_value("t6_res_data1", we_data[s_we + 1], 2);
        check_value("t6_l1_cycles", n_l1 - s_l1, 2 * N1);
        check_value("t6_l3_cycles", n_l3 - s_l3, 2 * N3);
        check_value("t6_idle_busy", bus_if.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
